// File: rtl/datapath.sv
// Single-bus CPU datapath: register file, PC/IR/MAR/MDR, Y/Z/HI/LO, in-port and ALU.
// Define DATAPATH_MEM_EN to replace the external Mdatain path with an internal 512x32 RAM.
module datapath_alu (
    input  logic [4:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] res
);
    logic [4:0]         sh;
    logic signed [63:0] prod;
    logic signed [31:0] quo;
    logic signed [31:0] rem;
    logic [63:0]        dbl;
    logic [63:0]        rot_r;
    logic [63:0]        rot_l;

    assign sh    = b[4:0];
    assign prod  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign dbl   = {a, a};
    assign rot_r = dbl >> sh;
    assign rot_l = dbl << sh;

    // Most-negative / -1 overflows; pin it to the wrapped quotient explicitly.
    always_comb begin
        quo = '0;
        rem = '0;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            quo = $signed(a);
            rem = '0;
        end else if (b != 32'd0) begin
            quo = $signed(a) / $signed(b);
            rem = $signed(a) % $signed(b);
        end
    end

    always_comb begin
        res = '0;
        case (op)
            5'b00100:          res[31:0] = a - b;
            5'b00101, 5'b01101: res[31:0] = a & b;
            5'b00110, 5'b01110: res[31:0] = a | b;
            5'b00111:          res[31:0] = a >> sh;
            5'b01000:          res[31:0] = 32'($signed(a) >>> sh);
            5'b01001:          res[31:0] = a << sh;
            5'b01010:          res[31:0] = rot_r[31:0];
            5'b01011:          res[31:0] = rot_l[63:32];
            5'b01111:          res = prod;
            5'b10000:          res = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {rem, quo};
            5'b10001:          res[31:0] = -b;
            5'b10010:          res[31:0] = ~b;
            default:           res[31:0] = a + b;
        endcase
    end
endmodule

module datapath (
    input  logic        PCout,
    input  logic        Zlowout,
    input  logic        Zhighout,
    input  logic        MDRout,
    input  logic        R2out,
    input  logic        R3out,
    input  logic        MARin,
    input  logic        Zin,
    input  logic        PCin,
    input  logic        MDRin,
    input  logic        IRin,
    input  logic        Yin,
    input  logic        LOin,
    input  logic        HIin,
    input  logic        IncPC,
    input  logic        Read,
    input  logic [4:0]  opcode,
    input  logic        R1in,
    input  logic        R2in,
    input  logic        R3in,
    input  logic        Clock,
    input  logic [31:0] Mdatain,
    input  logic        clear,
    input  logic        GRA,
    input  logic        GRB,
    input  logic        GRC,
    input  logic        Rin,
    input  logic        Rout,
    input  logic        BAout,
    input  logic        Write,
    input  logic        Cout,
    input  logic        InportOut,
    input  logic [31:0] InportIn,
    output logic [31:0] BusMuxOut
);
    logic [15:0][31:0] rf;
    logic [31:0] pc, ir, mar, mdr, y, hi, lo, inport, zhi, zlo;
    logic [31:0] bus;
    logic [31:0] c_sext;
    logic [31:0] mem_data;
    logic [63:0] alu_res;
    logic [3:0]  sel_idx;

    assign sel_idx = ({4{GRA}} & ir[26:23]) | ({4{GRB}} & ir[22:19]) | ({4{GRC}} & ir[18:15]);
    assign c_sext  = {{13{ir[18]}}, ir[18:0]};

    // Fixed-priority bus mux; BAout treats R0 as a hard zero for base addressing.
    always_comb begin
        bus = '0;
        if (Rout)           bus = rf[sel_idx];
        else if (BAout)     bus = (sel_idx == 4'd0) ? 32'd0 : rf[sel_idx];
        else if (R2out)     bus = rf[2];
        else if (R3out)     bus = rf[3];
        else if (PCout)     bus = pc;
        else if (MDRout)    bus = mdr;
        else if (Zhighout)  bus = zhi;
        else if (Zlowout)   bus = zlo;
        else if (InportOut) bus = inport;
        else if (Cout)      bus = c_sext;
    end

    assign BusMuxOut = bus;

    datapath_alu u_alu (
        .op  (opcode),
        .a   (y),
        .b   (bus),
        .res (alu_res)
    );

`ifdef DATAPATH_MEM_EN
    logic [31:0] ram [512];
    logic        unused_bits;

    // RAM is deliberately outside clear so contents survive a reset.
    always_ff @(posedge Clock) begin
        if (Write) ram[mar[8:0]] <= mdr;
    end

    assign mem_data    = ram[mar[8:0]];
    assign unused_bits = ^{Mdatain, mar[31:9], hi, lo, ir[31:27]};
`else
    logic unused_bits;

    assign mem_data    = Mdatain;
    assign unused_bits = ^{Write, mar, hi, lo, ir[31:27]};
`endif

    always_ff @(posedge Clock) begin
        if (clear) begin
            rf <= '0;
        end else begin
            if (Rin)  rf[sel_idx] <= bus;
            if (R1in) rf[1] <= bus;
            if (R2in) rf[2] <= bus;
            if (R3in) rf[3] <= bus;
        end
    end

    always_ff @(posedge Clock) begin
        if (clear) begin
            pc     <= '0;
            ir     <= '0;
            mar    <= '0;
            mdr    <= '0;
            y      <= '0;
            hi     <= '0;
            lo     <= '0;
            inport <= '0;
            zhi    <= '0;
            zlo    <= '0;
        end else begin
            inport <= InportIn;
            if (PCin)  pc  <= IncPC ? pc + 32'd1 : bus;
            if (IRin)  ir  <= bus;
            if (MARin) mar <= bus;
            if (MDRin) mdr <= Read ? mem_data : bus;
            if (Yin)   y   <= bus;
            if (HIin)  hi  <= bus;
            if (LOin)  lo  <= bus;
            if (Zin)   {zhi, zlo} <= alu_res;
        end
    end
endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath: ALU vector table plus hand sequences for bus, PC, IR and memory paths.
module tb_datapath;
    logic        PCout, Zlowout, Zhighout, MDRout, R2out, R3out;
    logic        MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin, IncPC, Read;
    logic [4:0]  opcode;
    logic        R1in, R2in, R3in;
    logic        Clock = 1'b0;
    logic [31:0] Mdatain;
    logic        clear;
    logic        GRA, GRB, GRC, Rin, Rout, BAout, Write, Cout, InportOut;
    logic [31:0] InportIn;
    logic [31:0] BusMuxOut;

    int n_vec = 0;
    int n_bad = 0;

    datapath dut (
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
        .R2out(R2out), .R3out(R3out), .MARin(MARin), .Zin(Zin), .PCin(PCin),
        .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .LOin(LOin), .HIin(HIin),
        .IncPC(IncPC), .Read(Read), .opcode(opcode), .R1in(R1in), .R2in(R2in),
        .R3in(R3in), .Clock(Clock), .Mdatain(Mdatain), .clear(clear),
        .GRA(GRA), .GRB(GRB), .GRC(GRC), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .Write(Write), .Cout(Cout), .InportOut(InportOut), .InportIn(InportIn),
        .BusMuxOut(BusMuxOut)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] y;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vt[21];

    task automatic clr_ctl();
        PCout = 0; Zlowout = 0; Zhighout = 0; MDRout = 0; R2out = 0; R3out = 0;
        MARin = 0; Zin = 0; PCin = 0; MDRin = 0; IRin = 0; Yin = 0; LOin = 0; HIin = 0;
        IncPC = 0; Read = 0; opcode = 5'd0; R1in = 0; R2in = 0; R3in = 0;
        GRA = 0; GRB = 0; GRC = 0; Rin = 0; Rout = 0; BAout = 0; Write = 0;
        Cout = 0; InportOut = 0;
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
        clr_ctl();
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Caller raises the strobe(s) first; this settles, compares and drops them.
    task automatic bus_chk(input string nm, input logic [31:0] exp);
        #1;
        check(nm, BusMuxOut, exp);
        clr_ctl();
    endtask

    // Present v through the in-port; the next step can then drive it onto the bus.
    task automatic via_in(input logic [31:0] v);
        InportIn = v;
        step();
        InportOut = 1;
    endtask

    initial begin
        vt[0]  = '{5'b00000, 32'd5,          32'd7,          32'd0,          32'd12};
        vt[1]  = '{5'b01100, 32'hFFFF_FFFF,  32'd1,          32'd0,          32'd0};
        vt[2]  = '{5'b00100, 32'd3,          32'd5,          32'd0,          32'hFFFF_FFFE};
        vt[3]  = '{5'b00101, 32'hF0F0_1234,  32'h0FF0_FFFF,  32'd0,          32'h00F0_1234};
        vt[4]  = '{5'b01110, 32'hF000_0000,  32'h0000_000F,  32'd0,          32'hF000_000F};
        vt[5]  = '{5'b00111, 32'h8000_0000,  32'd4,          32'd0,          32'h0800_0000};
        vt[6]  = '{5'b01000, 32'h8000_0000,  32'd4,          32'd0,          32'hF800_0000};
        vt[7]  = '{5'b01001, 32'h0000_0001,  32'd31,         32'd0,          32'h8000_0000};
        vt[8]  = '{5'b01010, 32'h0000_0001,  32'd1,          32'd0,          32'h8000_0000};
        vt[9]  = '{5'b01011, 32'h8000_0001,  32'd4,          32'd0,          32'h0000_0018};
        vt[10] = '{5'b01010, 32'h1234_5678,  32'h0000_0020,  32'd0,          32'h1234_5678};
        vt[11] = '{5'b01111, 32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  32'hFFFF_FFFA};
        vt[12] = '{5'b01111, 32'h0001_0000,  32'h0001_0000,  32'd1,          32'd0};
        vt[13] = '{5'b10000, 32'd7,          32'd2,          32'd1,          32'd3};
        vt[14] = '{5'b10000, 32'd7,          32'd0,          32'd7,          32'hFFFF_FFFF};
        vt[15] = '{5'b10000, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD};
        vt[16] = '{5'b10001, 32'd9,          32'd5,          32'd0,          32'hFFFF_FFFB};
        vt[17] = '{5'b10010, 32'd9,          32'h0000_FFFF,  32'd0,          32'hFFFF_0000};
        vt[18] = '{5'b10011, 32'd2,          32'd3,          32'd0,          32'd5};
        vt[19] = '{5'b01101, 32'h0000_00FF,  32'h0000_000F,  32'd0,          32'h0000_000F};
        vt[20] = '{5'b00110, 32'd1,          32'd2,          32'd0,          32'd3};

        clr_ctl();
        Mdatain  = 32'd0;
        InportIn = 32'h0000_1234;
        clear    = 1;
        step();
        step();
        PCout = 1;     bus_chk("reset_pc", 32'd0);
        Zlowout = 1;   bus_chk("reset_zlo", 32'd0);
        Zhighout = 1;  bus_chk("reset_zhi", 32'd0);
        InportOut = 1; bus_chk("reset_inport", 32'd0);
        bus_chk("idle_bus", 32'd0);
        clear = 0;
        step();
        InportOut = 1; bus_chk("inport_delay", 32'h0000_1234);

        for (int i = 0; i < 21; i++) begin
            via_in(vt[i].y); Yin = 1; step();
            via_in(vt[i].b); Zin = 1; opcode = vt[i].op; step();
            Zlowout = 1;  bus_chk($sformatf("alu%0d_lo", i), vt[i].lo);
            Zhighout = 1; bus_chk($sformatf("alu%0d_hi", i), vt[i].hi);
        end

        // PC increment, wrap, and clear overriding enables
        via_in(32'd5); PCin = 1; step();
        PCin = 1; IncPC = 1; step();
        PCout = 1; bus_chk("pc_inc", 32'd6);
        via_in(32'hFFFF_FFFF); PCin = 1; step();
        PCin = 1; IncPC = 1; step();
        PCout = 1; bus_chk("pc_wrap", 32'd0);
        via_in(32'd9); PCin = 1; step();
        clear = 1; PCin = 1; IncPC = 1; step();
        clear = 0;
        PCout = 1; bus_chk("clear_over_pcin", 32'd0);

        // IR 0x01000095: Ra=2, Rb=0, Rc=0
        via_in(32'h0100_0095); IRin = 1; step();
        GRB = 1; BAout = 1; bus_chk("ba_r0_zero", 32'd0);
        Cout = 1; bus_chk("cout_sext_pos", 32'h0000_0095);
        via_in(32'h0000_DEAD); GRA = 1; Rin = 1; step();
        R2out = 1; bus_chk("rin_r2", 32'h0000_DEAD);
        GRA = 1; Rout = 1; bus_chk("rout_r2", 32'h0000_DEAD);
        GRA = 1; BAout = 1; bus_chk("ba_r2", 32'h0000_DEAD);
        R2out = 1; MDRout = 1; PCout = 1; bus_chk("prio_r2", 32'h0000_DEAD);
        via_in(32'h0000_BEEF); R3in = 1; step();
        R3out = 1; PCout = 1; bus_chk("r3_direct", 32'h0000_BEEF);
        GRB = 1; Rout = 1; R3out = 1; bus_chk("prio_rout_r0", 32'd0);
        via_in(32'h0004_0001); IRin = 1; step();
        Cout = 1; bus_chk("cout_sext_neg", 32'hFFFC_0001);

`ifndef DATAPATH_MEM_EN
        Mdatain = 32'h0100_0095; Read = 1; MDRin = 1; step();
        MDRout = 1; IRin = 1; step();
        MDRout = 1; bus_chk("mdr_read", 32'h0100_0095);
        GRB = 1; BAout = 1; bus_chk("req33_ba", 32'd0);
        Cout = 1; bus_chk("req33_cout", 32'h0000_0095);
        Yin = 1; step();
        Cout = 1; Zin = 1; opcode = 5'b00000; step();
        Zlowout = 1; bus_chk("req33_zlo", 32'h0000_0095);
        Write = 1; Mdatain = 32'h1111_2222; step();
        via_in(32'h0000_0077); MDRin = 1; step();
        MDRout = 1; bus_chk("mdr_from_bus", 32'h0000_0077);
`else
        via_in(32'h0000_0010); MARin = 1; step();
        via_in(32'h0000_CAFE); MDRin = 1; step();
        Write = 1; step();
        via_in(32'd0); MDRin = 1; step();
        MDRout = 1; bus_chk("mdr_cleared", 32'd0);
        Read = 1; MDRin = 1; step();
        MDRout = 1; bus_chk("ram_read", 32'h0000_CAFE);
        clear = 1; step();
        clear = 0;
        via_in(32'h0000_0010); MARin = 1; step();
        Read = 1; MDRin = 1; step();
        MDRout = 1; bus_chk("ram_survives_clear", 32'h0000_CAFE);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 Clock  input  1  sole clock; all state updates on rising edge.
REQ-002 clear  input  1  synchronous, active-high reset.
REQ-003 Port order SHALL be: PCout, Zlowout, Zhighout, MDRout, R2out, R3out, MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin, IncPC, Read, opcode, R1in, R2in, R3in, Clock, Mdatain, clear, GRA, GRB, GRC, Rin, Rout, BAout, Write, Cout, InportOut, InportIn, BusMuxOut.
REQ-004 PCout, Zlowout, Zhighout, MDRout, R2out, R3out, InportOut, Cout  input  1 each  bus-drive strobes.
REQ-005 MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin  input  1 each  register load enables.
REQ-006 R1in, R2in, R3in  input  1 each  direct load of R1/R2/R3 from bus.
REQ-007 IncPC  input  1  with PCin, PC <= PC+1 instead of bus.
REQ-008 Read, Write  input  1 each  memory read (MDR source select) / memory write.
REQ-009 opcode  input  5  ALU operation select.
REQ-010 Mdatain  input  32  external memory data into MDR.
REQ-011 GRA, GRB, GRC  input  1 each  select IR field Ra[26:23], Rb[22:19], Rc[18:15].
REQ-012 Rin, Rout, BAout  input  1 each  load / drive / base-address-drive selected register.
REQ-013 InportIn  input  32  in-port data, sampled every cycle.
REQ-014 BusMuxOut  output  32  current bus value (combinational).

Function
REQ-015 State: R0-R15, PC, IR, MAR, MDR, Y, HI, LO, InPort (32 b each), Z (64 b: ZHI/ZLO).
REQ-016 Bus priority (first active wins, none -> 0): Rout/BAout, R2out, R3out, PCout, MDRout, Zhighout, Zlowout, InportOut, Cout.
REQ-017 Selected register index = OR of enabled IR fields (GRA/GRB/GRC); Rin loads it, Rout drives it; BAout drives it except R0 drives 0.
REQ-018 Cout drives IR[18:0] sign-extended to 32 b.
REQ-019 Load enables capture bus at clock edge; MAR, IR, Y, HI, LO, R1-R3 direct enables same edge as Rin (direct enable wins on same register).
REQ-020 MDRin: MDR <= memory data if Read=1, else bus.
REQ-021 PCin&IncPC: PC <= PC+1 (wrap 0xFFFFFFFF->0); PCin alone: PC <= bus.
REQ-022 ALU A=Y, B=bus; Zin loads result; 32-bit results give ZHI=0.
REQ-023 opcodes 00000-00011, 01100 ADD; 00100 SUB; 00101/01101 AND; 00110/01110 OR; 00111 SHR; 01000 SHRA; 01001 SHL; 01010 ROR; 01011 ROL; 10001 NEG(B); 10010 NOT(B); others ADD.
REQ-024 Shift/rotate amount B[4:0]; ADD/SUB modulo 2^32, no flags.
REQ-025 01111 MUL: signed 64-bit Y*B into {ZHI,ZLO}.
REQ-026 10000 DIV signed: ZLO quotient (truncate toward zero), ZHI remainder (sign of dividend); B=0 -> ZLO=0xFFFFFFFF, ZHI=Y.
REQ-027 InPort <= InportIn every cycle; bus sees one-cycle-delayed value.

Reset
REQ-028 clear=1 at edge zeroes every register incl. Z, HI, LO, InPort; BusMuxOut then 0 when no strobe; clear overrides all enables.
REQ-029 Memory contents unaffected by clear.

Configuration
REQ-030 Macro DATAPATH_MEM_EN defined: internal 512x32 RAM addressed MAR[8:0], memory data = RAM[MAR], Write stores MDR at edge; Mdatain ignored.
REQ-031 Macro undefined: memory data = Mdatain, Write ignored, no RAM.

Verification
REQ-032 clear pulse then PCout=1 -> BusMuxOut=0x00000000.
REQ-033 No macro: Mdatain=0x01000095, Read+MDRin, then MDRout+IRin; GRB+BAout -> bus 0; Cout -> bus 0x00000095; Y<=0, Cout+Zin opcode 00000 -> Zlowout 0x95.
REQ-034 PC=5, PCin+IncPC -> PCout shows 6.
REQ-035 Y=0xFFFFFFFE, bus=3, opcode 01111 -> Zhighout 0xFFFFFFFF, Zlowout 0xFFFFFFFA.
REQ-036 Y=7, bus=2, opcode 10000 -> ZLO=3, ZHI=1; bus=0 -> ZLO=0xFFFFFFFF, ZHI=7.
REQ-037 DATAPATH_MEM_EN: MAR=0x10, MDR=0xCAFE, Write; then Read+MDRin, MDRout -> 0x0000CAFE.
